// File: rtl/regset_wb_arbiter.sv
// Writeback arbiter for the register set's single write port: grants one of two
// requesters per cycle and presents the winning write one cycle later.
module regset_wb_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int PRIO_MODE = 0
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          hold,
  input  logic          flush,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic [DW-1:0] D,
  output logic [AW-1:0] A_D,
  output logic          write_enable,
  output logic          wb_busy,
  output logic [15:0]   grant_cnt0,
  output logic [15:0]   grant_cnt1
);

  logic          r_last_grant;
  logic [DW-1:0] r_d;
  logic [AW-1:0] r_ad;
  logic          r_we;
  logic [15:0]   r_cnt0;
  logic [15:0]   r_cnt1;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_xfer;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  // r_last_grant=1 means req1 won last, so req0 wins the next contested cycle
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!hold) begin
      if (req0_valid && (PRIO_MODE != 0 || !req1_valid || r_last_grant))
        w_gnt0 = 1'b1;
      else if (req1_valid)
        w_gnt1 = 1'b1;
    end
  end

  assign w_xfer = w_gnt0 | w_gnt1;
  assign w_addr = w_gnt1 ? req1_addr : req0_addr;
  assign w_data = w_gnt1 ? req1_data : req0_data;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_last_grant <= 1'b1;
      r_d          <= '0;
      r_ad         <= '0;
      r_we         <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      if (w_xfer) begin
        r_d          <= w_data;
        r_ad         <= w_addr;
        r_last_grant <= w_gnt1;
      end
      // r0 is hardwired, so address-0 writes are accepted but never strobed
      r_we <= w_xfer && (w_addr != '0) && !flush;
      if (w_gnt0 && r_cnt0 != '1)
        r_cnt0 <= r_cnt0 + 16'd1;
      if (w_gnt1 && r_cnt1 != '1)
        r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign req0_ready   = w_gnt0;
  assign req1_ready   = w_gnt1;
  assign D            = r_d;
  assign A_D          = r_ad;
  assign write_enable = r_we;
  assign wb_busy      = r_we;
  assign grant_cnt0   = r_cnt0;
  assign grant_cnt1   = r_cnt1;

endmodule

// File: tb/tb_regset_wb_arbiter.sv
// Bench for regset_wb_arbiter: instance 0 round-robin, instance 1 fixed priority,
// both compared every cycle against a behavioural model of the arbitration rules.
module tb_regset_wb_arbiter;

  logic clk = 1'b0;
  logic RES = 1'b0;
  logic hold = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       v0, v1;
  logic [1:0][4:0]  a0, a1;
  logic [1:0][31:0] d0, d1;
  logic [1:0]       r0, r1, we, busy;
  logic [1:0][31:0] Dq;
  logic [1:0][4:0]  ADq;
  logic [1:0][15:0] c0, c1;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      regset_wb_arbiter #(.DW(32), .AW(5), .PRIO_MODE(g)) u_dut (
        .CLK(clk), .RES(RES), .hold(hold), .flush(flush),
        .req0_valid(v0[g]), .req0_addr(a0[g]), .req0_data(d0[g]), .req0_ready(r0[g]),
        .req1_valid(v1[g]), .req1_addr(a1[g]), .req1_data(d1[g]), .req1_ready(r1[g]),
        .D(Dq[g]), .A_D(ADq[g]), .write_enable(we[g]), .wb_busy(busy[g]),
        .grant_cnt0(c0[g]), .grant_cnt1(c1[g])
      );
    end
  endgenerate

  // Behavioural model state
  int unsigned      m_c0[2];
  int unsigned      m_c1[2];
  int               m_last[2];
  logic [1:0][31:0] m_D;
  logic [1:0][4:0]  m_AD;
  logic [1:0]       m_we;
  int               w[2];
  logic [1:0]       acc0, acc1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner index for instance m: -1 none, 0 or 1
  function automatic int winner(input int m, input int last);
    if (hold) return -1;
    if (v0[m] && v1[m]) return (m == 1) ? 0 : 1 - last;
    if (v0[m]) return 0;
    if (v1[m]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_c0[m] = 0; m_c1[m] = 0; m_last[m] = 1;
      m_D[m] = '0; m_AD[m] = '0; m_we[m] = 1'b0;
    end
  endtask

  // Entered just after a negedge with stimulus already driven; leaves at the next negedge
  task automatic cycle();
    #1;
    for (int m = 0; m < 2; m++) begin
      w[m] = winner(m, m_last[m]);
      chk($sformatf("ready0[%0d]", m), {31'd0, r0[m]}, {31'd0, w[m] == 0});
      chk($sformatf("ready1[%0d]", m), {31'd0, r1[m]}, {31'd0, w[m] == 1});
      chk($sformatf("we[%0d]", m), {31'd0, we[m]}, {31'd0, m_we[m]});
      chk($sformatf("busy[%0d]", m), {31'd0, busy[m]}, {31'd0, m_we[m]});
      chk($sformatf("D[%0d]", m), Dq[m], m_D[m]);
      chk($sformatf("A_D[%0d]", m), {27'd0, ADq[m]}, {27'd0, m_AD[m]});
      chk($sformatf("cnt0[%0d]", m), {16'd0, c0[m]}, m_c0[m]);
      chk($sformatf("cnt1[%0d]", m), {16'd0, c1[m]}, m_c1[m]);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      acc0[m] = (w[m] == 0);
      acc1[m] = (w[m] == 1);
      if (w[m] >= 0) begin
        m_D[m]    = (w[m] == 0) ? d0[m] : d1[m];
        m_AD[m]   = (w[m] == 0) ? a0[m] : a1[m];
        m_we[m]   = (m_AD[m] != 5'd0) && !flush;
        m_last[m] = w[m];
        if (w[m] == 0 && m_c0[m] < 65535) m_c0[m]++;
        if (w[m] == 1 && m_c1[m] < 65535) m_c1[m]++;
      end else begin
        m_we[m] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    RES = 1'b0; hold = 1'b0; flush = 1'b0;
    v0 = '0; v1 = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    RES = 1'b1;
  endtask

  task automatic set_both(input logic vv0, input logic [4:0] aa0, input logic [31:0] dd0,
                          input logic vv1, input logic [4:0] aa1, input logic [31:0] dd1);
    for (int m = 0; m < 2; m++) begin
      v0[m] = vv0; a0[m] = aa0; d0[m] = dd0;
      v1[m] = vv1; a1[m] = aa1; d1[m] = dd1;
    end
  endtask

  initial begin
    logic [4:0] exp_ad0[4];
    exp_ad0 = '{5'd3, 5'd7, 5'd3, 5'd7};

    // Idle after reset
    apply_reset();
    for (int i = 0; i < 10; i++) cycle();
    for (int m = 0; m < 2; m++) begin
      chk("idle_we", {31'd0, we[m]}, 32'd0);
      chk("idle_cnt0", {16'd0, c0[m]}, 32'd0);
    end

    // Single req0 write
    set_both(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    cycle();
    set_both(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int m = 0; m < 2; m++) begin
      chk("t2_we", {31'd0, we[m]}, 32'd1);
      chk("t2_ad", {27'd0, ADq[m]}, 32'd5);
      chk("t2_d", Dq[m], 32'hDEADBEEF);
      chk("t2_cnt0", {16'd0, c0[m]}, 32'd1);
    end
    cycle();

    // Contested stream: alternation vs fixed priority
    apply_reset();
    set_both(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_ad_rr", {27'd0, ADq[0]}, {27'd0, exp_ad0[i]});
      chk("t3_ad_fp", {27'd0, ADq[1]}, 32'd3);
    end
    chk("t3_cnt0_rr", {16'd0, c0[0]}, 32'd2);
    chk("t3_cnt1_rr", {16'd0, c1[0]}, 32'd2);
    chk("t4_cnt0_fp", {16'd0, c0[1]}, 32'd4);
    chk("t4_cnt1_fp", {16'd0, c1[1]}, 32'd0);

    // Address 0 accepted but not written
    apply_reset();
    set_both(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    cycle();
    set_both(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int m = 0; m < 2; m++) begin
      chk("t5_cnt1", {16'd0, c1[m]}, 32'd1);
      chk("t5_we", {31'd0, we[m]}, 32'd0);
    end

    // Hold, then flush on the first grant, then a normal write
    set_both(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    hold = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("t6_cnt0", {16'd0, c0[m]}, 32'd1);
      chk("t6_we_flushed", {31'd0, we[m]}, 32'd0);
    end
    cycle();
    chk("t6_we_after", {31'd0, we[0]}, 32'd1);
    chk("t6_ad_rr", {27'd0, ADq[0]}, 32'd7);
    chk("t6_ad_fp", {27'd0, ADq[1]}, 32'd3);

    // Random traffic with handshake-respecting requesters
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      hold  = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 5) == 0);
      for (int m = 0; m < 2; m++) begin
        if (!v0[m] && $urandom_range(0, 2) != 0) begin
          v0[m] = 1'b1;
          a0[m] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          d0[m] = $urandom;
        end
        if (!v1[m] && $urandom_range(0, 2) != 0) begin
          v1[m] = 1'b1;
          a1[m] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          d1[m] = $urandom;
        end
      end
      cycle();
      for (int m = 0; m < 2; m++) begin
        if (acc0[m]) v0[m] = 1'b0;
        if (acc1[m]) v1[m] = 1'b0;
      end
      if (i == 1500) begin
        // Reset between edges while a write is in flight
        hold = 1'b0; flush = 1'b0;
        set_both(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
        cycle();
        chk("midrst_we_before", {31'd0, we[0]}, 32'd1);
        #2 RES = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
          chk("midrst_we", {31'd0, we[m]}, 32'd0);
          chk("midrst_busy", {31'd0, busy[m]}, 32'd0);
          chk("midrst_cnt0", {16'd0, c0[m]}, 32'd0);
        end
        model_reset();
        set_both(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        RES = 1'b1;
      end
    end

    // Counter saturation
    apply_reset();
    hold = 1'b0; flush = 1'b0;
    set_both(1'b1, 5'd4, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 65540; i++) begin
      for (int m = 0; m < 2; m++) d0[m] = i;
      cycle();
    end
    for (int m = 0; m < 2; m++) begin
      chk("sat_cnt0", {16'd0, c0[m]}, 32'h0000FFFF);
      chk("sat_cnt1", {16'd0, c1[m]}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regset_wb_arbiter.md
Name: regset_wb_arbiter

Overview:
Writeback arbiter and sequencer for the 32x32 register set's single write port. Two pipeline requesters (req0 = execute/ALU result, req1 = memory/load result) compete for the port through valid/ready handshakes. The block grants one requester per cycle, registers the winning write, and drives the register set's D / A_D / write_enable inputs one cycle later. It also owns the hold and flush sequencing for the write port.

Parameters:
DW, 32, data width of D and of the request data.
AW, 5, register address width (32 registers).
PRIO_MODE, 0, 0 = round-robin between req0/req1; 1 = fixed priority, req0 always wins.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RES  in  1  reset; asynchronous, active-low.
hold  in  1  pipeline stall; while 1, no grants are issued.
flush  in  1  discard the registered write in the output stage.
req0_valid  in  1  requester 0 has a write pending.
req0_addr  in  AW  requester 0 destination register.
req0_data  in  DW  requester 0 write data.
req0_ready  out  1  requester 0 granted this cycle (combinational).
req1_valid  in  1  requester 1 has a write pending.
req1_addr  in  AW  requester 1 destination register.
req1_data  in  DW  requester 1 write data.
req1_ready  out  1  requester 1 granted this cycle (combinational).
D  out  DW  write data to the register set.
A_D  out  AW  write address to the register set.
write_enable  out  1  write strobe to the register set.
wb_busy  out  1  output stage holds a valid write (forwarding/hazard hint).
grant_cnt0  out  16  saturating count of req0 acceptances.
grant_cnt1  out  16  saturating count of req1 acceptances.

Behaviour:
- Reset (RES=0, async): D=0, A_D=0, write_enable=0, wb_busy=0, grant counters=0, last_grant=1 (req0 wins the first contested cycle).
- Handshake: a transfer occurs when reqN_valid && reqN_ready. Requesters hold valid/addr/data stable until accepted; valid must not drop before acceptance.
- At most one ready per cycle. While hold=1: both ready=0.
- Grant, round-robin (PRIO_MODE=0):
  - Only one valid: that requester is granted.
  - Both valid: grant the one not in last_grant.
  - last_grant updates only on an actual transfer.
- Grant, PRIO_MODE=1: req0 wins whenever req0 is valid. last_grant is ignored.
- Output stage (1-cycle latency): a transfer in cycle N loads D/A_D from the winner at edge N. write_enable=1 and wb_busy=1 during cycle N+1. With no transfer: write_enable=0, wb_busy=0, D/A_D hold their last values.
- Address 0: the request is accepted normally (ready=1, counted, updates last_grant). write_enable stays 0 and wb_busy stays 0, because r0 is hardwired.
- Flush:
  - flush=1 at an edge clears write_enable/wb_busy for the next cycle.
  - A transfer in the same cycle as flush is still accepted and counted, but its write is suppressed. Flush wins.
- Hold and flush together: no grant and output cleared.
- Counters saturate at 0xFFFF; no wrap.
- Reset mid-operation: the in-flight write is lost and write_enable drops immediately (async).

Test Plan:
1. Reset then release, no valids -> write_enable=0, ready0=ready1=0, counters=0 for 10 cycles.
2. req0 only: valid, addr=5, data=0xDEADBEEF -> ready0=1 same cycle; next cycle write_enable=1, A_D=5, D=0xDEADBEEF; grant_cnt0=1.
3. PRIO_MODE=0, both valid continuously (req0 addr=3, req1 addr=7) for 4 transfers -> grant order req0, req1, req0, req1; A_D sequence 3, 7, 3, 7; counts 2/2.
4. PRIO_MODE=1, same stimulus -> req0 granted all 4 cycles; req1_ready=0 throughout; grant_cnt1=0.
5. req1 addr=0, data=0x1234 -> ready1=1, grant_cnt1=1, write_enable stays 0.
6. hold=1 for 3 cycles with both valid -> no ready, write_enable=0. Then flush asserted on the first grant edge after hold drops -> grant counted, write_enable=0 next cycle. Then a following grant writes normally.
